// File: rtl/rs_multi_cdb_if.sv
// Dispatch / CDB / issue bundle for one reservation station.
// master = dispatch, CDB and FU side (drives requests, broadcasts, issue_ready).
// slave  = reservation station side (drives status and the issue register).
interface rs_multi_cdb_if #(
    parameter int RS_SIZE_BIT = 3,
    parameter int ROB_W       = 4,
    parameter int TYPE_W      = 5,
    parameter int NUM_CDB     = 2
) ();
    logic                       rdy_in;
    logic                       flush;
    logic                       inst_valid;
    logic [TYPE_W-1:0]          inst_type;
    logic [ROB_W-1:0]           inst_rob_id;
    logic [31:0]                inst_r1;
    logic [31:0]                inst_r2;
    logic                       inst_has_dep1;
    logic                       inst_has_dep2;
    logic [ROB_W-1:0]           inst_dep1;
    logic [ROB_W-1:0]           inst_dep2;
    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB*ROB_W-1:0]   cdb_rob_id;
    logic [NUM_CDB*32-1:0]      cdb_value;
    logic                       full;
    logic [RS_SIZE_BIT:0]       count;
    logic                       overflow_err;
    logic                       issue_valid;
    logic                       issue_ready;
    logic [TYPE_W-1:0]          issue_type;
    logic [ROB_W-1:0]           issue_rob_id;
    logic [31:0]                issue_r1;
    logic [31:0]                issue_r2;

    modport master (
        output rdy_in, flush, inst_valid, inst_type, inst_rob_id, inst_r1, inst_r2,
               inst_has_dep1, inst_has_dep2, inst_dep1, inst_dep2,
               cdb_valid, cdb_rob_id, cdb_value, issue_ready,
        input  full, count, overflow_err, issue_valid, issue_type, issue_rob_id,
               issue_r1, issue_r2
    );

    modport slave (
        input  rdy_in, flush, inst_valid, inst_type, inst_rob_id, inst_r1, inst_r2,
               inst_has_dep1, inst_has_dep2, inst_dep1, inst_dep2,
               cdb_valid, cdb_rob_id, cdb_value, issue_ready,
        output full, count, overflow_err, issue_valid, issue_type, issue_rob_id,
               issue_r1, issue_r2
    );
endinterface

// File: rtl/rs_multi_cdb.sv
// Reservation station: holds decoded ops, snoops NUM_CDB broadcasts, issues one ready op per cycle.
// Latency: operand on CDB in cycle t -> issue_valid in t+1; inserted op eligible from t+1.
// Backpressure: issue register holds while issue_valid && !issue_ready; inserts while full are dropped (sticky overflow_err).
// Build option RS_OLDEST_FIRST_EN: age matrix selects the oldest eligible entry instead of the lowest index.
module rs_multi_cdb #(
    parameter int RS_SIZE_BIT = 3,
    parameter int ROB_W       = 4,
    parameter int TYPE_W      = 5,
    parameter int NUM_CDB     = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    rs_multi_cdb_if.slave rs_bus
);
    localparam int RS_SIZE = 1 << RS_SIZE_BIT;
    localparam int CNT_W   = RS_SIZE_BIT + 1;

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic [ROB_W-1:0]  rob;
        logic [31:0]       r1;
        logic [31:0]       r2;
        logic              dep1;
        logic              dep2;
        logic [ROB_W-1:0]  tag1;
        logic [ROB_W-1:0]  tag2;
    } ent_t;

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic [ROB_W-1:0]  rob;
        logic [31:0]       r1;
        logic [31:0]       r2;
    } iss_t;

    // Resolve pending operands against the CDB; scanning high to low lets the lowest channel win.
    function automatic ent_t wake_ent(input ent_t e, input logic [NUM_CDB-1:0] v,
                                      input logic [NUM_CDB*ROB_W-1:0] ids,
                                      input logic [NUM_CDB*32-1:0] vals);
        ent_t r;
        r = e;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (e.dep1 && v[k] && ids[k*ROB_W +: ROB_W] == e.tag1) begin
                r.dep1 = 1'b0;
                r.r1   = vals[k*32 +: 32];
            end
            if (e.dep2 && v[k] && ids[k*ROB_W +: ROB_W] == e.tag2) begin
                r.dep2 = 1'b0;
                r.r2   = vals[k*32 +: 32];
            end
        end
        return r;
    endfunction

    ent_t                   ent_q [RS_SIZE];
    ent_t                   ent_d [RS_SIZE];
    ent_t                   ent_w [RS_SIZE];
    ent_t                   ins_ent;
    logic [RS_SIZE-1:0]     busy_q, busy_d, elig, cand;
    iss_t                   iss_q, iss_d;
    logic                   iv_q, iv_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [RS_SIZE_BIT-1:0] sel_idx, free_idx;
    logic                   sel_any, full_w, do_ins, do_pop;

    assign full_w = (count_q == CNT_W'(RS_SIZE));

    // Forwarded view of every entry and of the incoming op for this cycle's broadcasts.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_w[i] = wake_ent(ent_q[i], rs_bus.cdb_valid, rs_bus.cdb_rob_id, rs_bus.cdb_value);
            elig[i]  = busy_q[i] && !ent_w[i].dep1 && !ent_w[i].dep2;
        end
        ins_ent = wake_ent('{typ: rs_bus.inst_type, rob: rs_bus.inst_rob_id,
                             r1: rs_bus.inst_r1, r2: rs_bus.inst_r2,
                             dep1: rs_bus.inst_has_dep1, dep2: rs_bus.inst_has_dep2,
                             tag1: rs_bus.inst_dep1, tag2: rs_bus.inst_dep2},
                           rs_bus.cdb_valid, rs_bus.cdb_rob_id, rs_bus.cdb_value);
    end

`ifdef RS_OLDEST_FIRST_EN
    // age_q[i][j] = 1 means entry i was inserted before entry j; only busy pairs are meaningful.
    logic [RS_SIZE-1:0] age_q [RS_SIZE];
    logic [RS_SIZE-1:0] age_d [RS_SIZE];

    // Candidate = eligible entry older than every other eligible entry.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            cand[i] = elig[i];
            for (int j = 0; j < RS_SIZE; j++)
                if (j != i && elig[j] && !age_q[i][j]) cand[i] = 1'b0;
        end
    end

    // A new entry becomes younger than everything currently held.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) age_d[i] = age_q[i];
        if (rs_bus.rdy_in && !rs_bus.flush && do_ins) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                age_d[free_idx][j] = 1'b0;
                if (j != int'(free_idx)) age_d[j][free_idx] = 1'b1;
            end
        end
    end

    // Age matrix register.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < RS_SIZE; i++) age_q[i] <= rst_in ? '0 : age_d[i];
    end
`else
    // Without age tracking every eligible entry is a candidate; lowest index wins below.
    always_comb cand = elig;
`endif

    // Lowest-index candidate to issue and lowest-index free slot to fill.
    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (cand[i])    sel_idx  = RS_SIZE_BIT'(i);
            if (!busy_q[i]) free_idx = RS_SIZE_BIT'(i);
        end
        sel_any = |cand;
        do_pop  = sel_any && (!iv_q || rs_bus.issue_ready);
        do_ins  = rs_bus.inst_valid && !full_w;
    end

    // Next state: hold when disabled, flush wins over insert and pop.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) ent_d[i] = ent_q[i];
        busy_d  = busy_q;
        iss_d   = iss_q;
        iv_d    = iv_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        if (rs_bus.rdy_in) begin
            if (rs_bus.inst_valid && full_w) ovf_d = 1'b1;
            if (rs_bus.flush) begin
                busy_d  = '0;
                iv_d    = 1'b0;
                count_d = '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) ent_d[i] = ent_w[i];
                if (do_pop) begin
                    iv_d            = 1'b1;
                    iss_d           = '{typ: ent_w[sel_idx].typ, rob: ent_w[sel_idx].rob,
                                        r1: ent_w[sel_idx].r1, r2: ent_w[sel_idx].r2};
                    busy_d[sel_idx] = 1'b0;
                end else if (rs_bus.issue_ready) begin
                    iv_d = 1'b0;
                end
                if (do_ins) begin
                    busy_d[free_idx] = 1'b1;
                    ent_d[free_idx]  = ins_ent;
                end
                count_d = count_q + CNT_W'(do_ins) - CNT_W'(do_pop);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
            busy_q  <= '0;
            iss_q   <= '0;
            iv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
            busy_q  <= busy_d;
            iss_q   <= iss_d;
            iv_q    <= iv_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign rs_bus.full         = full_w;
    assign rs_bus.count        = count_q;
    assign rs_bus.overflow_err = ovf_q;
    assign rs_bus.issue_valid  = iv_q;
    assign rs_bus.issue_type   = iss_q.typ;
    assign rs_bus.issue_rob_id = iss_q.rob;
    assign rs_bus.issue_r1     = iss_q.r1;
    assign rs_bus.issue_r2     = iss_q.r2;
endmodule

// File: tb/tb_rs_multi_cdb.sv
// Bench for rs_multi_cdb: directed scenarios plus randomized traffic against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are compared at the same point.
// Model keeps entries as records with an insertion sequence number.
module tb_rs_multi_cdb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_multi_cdb_if #(.RS_SIZE_BIT(3), .ROB_W(4), .TYPE_W(5), .NUM_CDB(2)) bus ();
    rs_multi_cdb #(.RS_SIZE_BIT(3), .ROB_W(4), .TYPE_W(5), .NUM_CDB(2)) dut (
        .clk_in(clk), .rst_in(rst), .rs_bus(bus));

    typedef struct {
        bit busy; bit [4:0] typ; bit [3:0] rob; bit [31:0] v1, v2;
        bit d1, d2; bit [3:0] t1, t2; int unsigned seq;
    } ment_t;

    ment_t       me [8];
    bit          m_iv, m_ovf;
    bit [4:0]    m_ity;
    bit [3:0]    m_irob;
    bit [31:0]   m_ir1, m_ir2;
    int unsigned m_seq;
    int          n_chk = 0, n_pass = 0;
    logic [3:0]  held_rob;
    logic [31:0] held_r1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit cdb_hit(input bit [3:0] tag, output bit [31:0] val);
        val = '0;
        for (int k = 0; k < 2; k++)
            if (bus.cdb_valid[k] && bus.cdb_rob_id[k*4 +: 4] == tag) begin
                val = bus.cdb_value[k*32 +: 32];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic int busy_cnt();
        int n = 0;
        for (int i = 0; i < 8; i++) if (me[i].busy) n++;
        return n;
    endfunction

    // Behavioural next state from the current model state and the inputs now on the bus.
    task automatic model_next();
        int nb, pick, f;
        bit full;
        bit [31:0] v;
        if (rst) begin
            for (int i = 0; i < 8; i++) me[i].busy = 0;
            m_iv = 0; m_ovf = 0; m_ity = 0; m_irob = 0; m_ir1 = 0; m_ir2 = 0;
            return;
        end
        if (!bus.rdy_in) return;
        nb = busy_cnt();
        full = (nb == 8);
        if (bus.inst_valid && full) m_ovf = 1;
        if (bus.flush) begin
            for (int i = 0; i < 8; i++) me[i].busy = 0;
            m_iv = 0;
            return;
        end
        f = -1;
        for (int i = 7; i >= 0; i--) if (!me[i].busy) f = i;
        for (int i = 0; i < 8; i++) if (me[i].busy) begin
            if (me[i].d1 && cdb_hit(me[i].t1, v)) begin me[i].d1 = 0; me[i].v1 = v; end
            if (me[i].d2 && cdb_hit(me[i].t2, v)) begin me[i].d2 = 0; me[i].v2 = v; end
        end
        pick = -1;
        for (int i = 0; i < 8; i++) if (me[i].busy && !me[i].d1 && !me[i].d2) begin
`ifdef RS_OLDEST_FIRST_EN
            if (pick < 0 || me[i].seq < me[pick].seq) pick = i;
`else
            if (pick < 0) pick = i;
`endif
        end
        if (pick >= 0 && (!m_iv || bus.issue_ready)) begin
            m_iv = 1; m_ity = me[pick].typ; m_irob = me[pick].rob;
            m_ir1 = me[pick].v1; m_ir2 = me[pick].v2; me[pick].busy = 0;
        end else if (bus.issue_ready) m_iv = 0;
        if (bus.inst_valid && !full) begin
            me[f].busy = 1; me[f].typ = bus.inst_type; me[f].rob = bus.inst_rob_id;
            me[f].v1 = bus.inst_r1; me[f].v2 = bus.inst_r2;
            me[f].d1 = bus.inst_has_dep1; me[f].d2 = bus.inst_has_dep2;
            me[f].t1 = bus.inst_dep1; me[f].t2 = bus.inst_dep2; me[f].seq = m_seq++;
            if (me[f].d1 && cdb_hit(me[f].t1, v)) begin me[f].d1 = 0; me[f].v1 = v; end
            if (me[f].d2 && cdb_hit(me[f].t2, v)) begin me[f].d2 = 0; me[f].v2 = v; end
        end
    endtask

    task automatic step();
        int nb;
        model_next();
        @(posedge clk);
        #1;
        nb = busy_cnt();
        chk("issue_valid", 32'(bus.issue_valid), 32'(m_iv));
        chk("count", 32'(bus.count), nb);
        chk("full", 32'(bus.full), 32'(nb == 8));
        chk("overflow", 32'(bus.overflow_err), 32'(m_ovf));
        if (m_iv) begin
            chk("issue_type", 32'(bus.issue_type), 32'(m_ity));
            chk("issue_rob", 32'(bus.issue_rob_id), 32'(m_irob));
            chk("issue_r1", bus.issue_r1, m_ir1);
            chk("issue_r2", bus.issue_r2, m_ir2);
        end
    endtask

    task automatic idle();
        bus.rdy_in = 1; bus.flush = 0; bus.inst_valid = 0; bus.issue_ready = 1;
        bus.cdb_valid = 0; bus.cdb_rob_id = 0; bus.cdb_value = 0;
    endtask

    task automatic ins(input bit [3:0] rob, input bit [31:0] r1, input bit [31:0] r2,
                       input bit hd1, input bit [3:0] d1, input bit hd2, input bit [3:0] d2);
        bus.inst_valid = 1; bus.inst_type = 5'(rob + 1); bus.inst_rob_id = rob;
        bus.inst_r1 = r1; bus.inst_r2 = r2;
        bus.inst_has_dep1 = hd1; bus.inst_dep1 = d1; bus.inst_has_dep2 = hd2; bus.inst_dep2 = d2;
    endtask

    task automatic cdb(input int ch, input bit [3:0] tag, input bit [31:0] val);
        bus.cdb_valid[ch] = 1'b1;
        bus.cdb_rob_id[ch*4 +: 4] = tag;
        bus.cdb_value[ch*32 +: 32] = val;
    endtask

    task automatic do_reset();
        rst = 1; idle(); bus.inst_valid = 0;
        step(); step();
        rst = 0;
    endtask

    initial begin
        m_seq = 0;
        bus.inst_type = 0; bus.inst_rob_id = 0; bus.inst_r1 = 0; bus.inst_r2 = 0;
        bus.inst_has_dep1 = 0; bus.inst_has_dep2 = 0; bus.inst_dep1 = 0; bus.inst_dep2 = 0;
        do_reset();
        chk("rst_issue_r1", bus.issue_r1, 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);

        // 1: no-dep op issues the cycle after insert.
        idle(); ins(4'd1, 32'd5, 32'd7, 0, 0, 0, 0); step();
        chk("t1_count1", 32'(bus.count), 32'd1);
        idle(); step();
        chk("t1_iv", 32'(bus.issue_valid), 32'd1);
        chk("t1_r1", bus.issue_r1, 32'd5);
        chk("t1_r2", bus.issue_r2, 32'd7);
        chk("t1_count0", 32'(bus.count), 32'd0);
        step();

        // 2: wakeup via CDB channel 1 two cycles after insert.
        ins(4'd2, 32'd0, 32'd9, 1, 4'd3, 0, 0); step();
        idle(); step();
        chk("t2_wait", 32'(bus.issue_valid), 32'd0);
        cdb(1, 4'd3, 32'h1234); cdb(0, 4'd5, 32'hDEAD); step();
        chk("t2_iv", 32'(bus.issue_valid), 32'd1);
        chk("t2_r1", bus.issue_r1, 32'h1234);
        idle(); step();

        // 3: dependency captured from a broadcast in the insert cycle.
        ins(4'd4, 32'd0, 32'd1, 1, 4'd9, 0, 0); cdb(0, 4'd9, 32'hAA); step();
        chk("t3_not_yet", 32'(bus.issue_valid), 32'd0);
        idle(); step();
        chk("t3_r1", bus.issue_r1, 32'hAA);
        step();

        // 4: fill, overflow, then backpressure holds the issue register.
        for (int i = 0; i < 8; i++) begin
            idle(); ins(4'(i), 32'(i * 3), 32'(i), 1, 4'd15, 0, 0); step();
        end
        idle(); ins(4'd9, 32'd0, 32'd0, 0, 0, 0, 0); step();
        chk("t4_full", 32'(bus.full), 32'd1);
        chk("t4_ovf", 32'(bus.overflow_err), 32'd1);
        chk("t4_count8", 32'(bus.count), 32'd8);
        idle(); bus.issue_ready = 0; cdb(0, 4'd15, 32'h55); step();
        held_rob = bus.issue_rob_id; held_r1 = bus.issue_r1;
        idle(); bus.issue_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_rob", 32'(bus.issue_rob_id), 32'(held_rob));
            chk("t4_hold_r1", bus.issue_r1, held_r1);
            chk("t4_count7", 32'(bus.count), 32'd7);
        end
        idle(); for (int i = 0; i < 9; i++) step();

        // 5: flush beats a same-cycle insert.
        for (int i = 0; i < 4; i++) begin
            idle(); ins(4'(i), 32'd0, 32'd0, 1, 4'd14, 0, 0); step();
        end
        idle(); bus.flush = 1; ins(4'd7, 32'd1, 32'd2, 0, 0, 0, 0); step();
        chk("t5_count", 32'(bus.count), 32'd0);
        chk("t5_iv", 32'(bus.issue_valid), 32'd0);
        chk("t5_full", 32'(bus.full), 32'd0);

        // 6: A pops, B lands in entry 1, C reuses entry 0; wake B and C together.
        do_reset();
        idle(); ins(4'd10, 32'd1, 32'd1, 0, 0, 0, 0); step();
        idle(); ins(4'd11, 32'd2, 32'd2, 1, 4'd6, 0, 0); step();
        idle(); ins(4'd12, 32'd3, 32'd3, 1, 4'd6, 0, 0); step();
        idle(); cdb(0, 4'd6, 32'h66); step();
`ifdef RS_OLDEST_FIRST_EN
        chk("t6_order", 32'(bus.issue_rob_id), 32'd11);
`else
        chk("t6_order", 32'(bus.issue_rob_id), 32'd12);
`endif
        idle(); step(); step();

        // Randomized traffic: a light-load phase, then a backpressured phase that fills the station.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.rdy_in        = ($urandom_range(9) != 0);
            bus.flush         = ($urandom_range(59) == 0);
            bus.inst_valid    = $urandom_range(1);
            bus.inst_type     = 5'($urandom);
            bus.inst_rob_id   = 4'($urandom);
            bus.inst_r1       = $urandom;
            bus.inst_r2       = $urandom;
            bus.inst_has_dep1 = $urandom_range(1);
            bus.inst_has_dep2 = $urandom_range(1);
            bus.inst_dep1     = 4'($urandom_range(3));
            bus.inst_dep2     = 4'($urandom_range(3));
            bus.cdb_valid     = 2'($urandom);
            bus.cdb_rob_id    = {4'($urandom_range(3)), 4'($urandom_range(3))};
            bus.cdb_value     = {$urandom, $urandom};
            bus.issue_ready   = (i < 1500) ? ($urandom_range(3) != 0) : ($urandom_range(4) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
